// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: accepts one memory-stage request, drives a word-addressed
// req/ready data memory, and returns the extended load value with a one-cycle done pulse.
module rv32i_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  ReadControl,
    input  logic [2:0]  WriteControl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             we_q, we_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [1:0]       off_q, off_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        req_illegal_c;
    logic        req_misaligned_c;
    logic        req_bad_c;
    logic [3:0]  st_be_c;
    logic [31:0] st_wdata_c;
    logic [7:0]  ld_byte_c;
    logic [15:0] ld_half_c;
    logic [31:0] ld_data_c;
    logic        timeout_c;

    // Request classification on the incoming (not yet latched) request.
    always_comb begin
        req_illegal_c    = 1'b0;
        req_misaligned_c = 1'b0;
        if (req_we) begin
            req_illegal_c    = (WriteControl > F3_W);
            req_misaligned_c = ((WriteControl == F3_H) && addr[0]) ||
                               ((WriteControl == F3_W) && (addr[1:0] != 2'b00));
        end else begin
            req_illegal_c    = (ReadControl inside {3'b011, 3'b110, 3'b111});
            req_misaligned_c = ((ReadControl[1:0] == 2'b01) && addr[0]) ||
                               ((ReadControl == F3_W) && (addr[1:0] != 2'b00));
        end
        req_bad_c = req_illegal_c || req_misaligned_c;
    end

    // Store lane placement: replicate data across lanes, enable only the addressed bytes.
    always_comb begin
        st_be_c    = 4'b1111;
        st_wdata_c = wdata;
        case (WriteControl)
            F3_B: begin
                st_be_c    = 4'b0001 << addr[1:0];
                st_wdata_c = {4{wdata[7:0]}};
            end
            F3_H: begin
                st_be_c    = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata_c = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction from the returned word using the latched offset and type.
    always_comb begin
        ld_byte_c = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ctrl_q)
            F3_B:    ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            F3_H:    ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
            F3_W:    ld_data_c = mem_rdata;
            F3_BU:   ld_data_c = {24'd0, ld_byte_c};
            F3_HU:   ld_data_c = {16'd0, ld_half_c};
            default: ld_data_c = 32'd0;
        endcase
    end

    assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_bad_c ? RESP : ACCESS;
            ACCESS:  if (mem_ready || timeout_c) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs follow the next state; bus fields are frozen at acceptance.
    always_comb begin
        we_d        = we_q;
        ctrl_d      = ctrl_q;
        off_d       = off_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_req_d   = (state_d == ACCESS);
        done_d      = (state_d == RESP);
        err_d       = 1'b0;
        rdata_d     = 32'd0;
        cnt_d       = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    ctrl_d      = req_we ? WriteControl : ReadControl;
                    off_d       = addr[1:0];
                    mem_we_d    = req_we;
                    mem_be_d    = req_we ? st_be_c : 4'b1111;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_wdata_d = st_wdata_c;
                    err_d       = req_bad_c;
                end
            end
            ACCESS: begin
                if (state_d == ACCESS) begin
                    cnt_d = (TIMEOUT_CYCLES != 0) ? cnt_q + CNT_W'(1) : '0;
                end else if (mem_ready) begin
                    rdata_d = we_q ? 32'd0 : ld_data_c;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            ctrl_q      <= 3'd0;
            off_q       <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            cnt_q       <= '0;
        end else begin
            we_q        <= we_d;
            ctrl_q      <= ctrl_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign stall     = ((state_q == IDLE) && req_valid) || (state_q == ACCESS);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
